// File: rtl/rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rst_sequencer
//  Description : Staged reset release for the clock-generator output domain.
//                Debounces a push-button and releases NUM_STAGES active-high
//                resets in order, bit 0 first, STAGE_DELAY cycles apart.
//                o_ready reports that every stage has been released.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_sequencer #(
  parameter int NUM_STAGES      = 3,
  parameter int STAGE_DELAY     = 16,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int BTN_ACTIVE      = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_btn,
  output logic [NUM_STAGES-1:0] o_rst,
  output logic                  o_ready
);

  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int DW = $clog2(STAGE_DELAY + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // The counters clear on the edge where they would hit their terminal count,
  // so each one is compared against "terminal - 1".
  localparam logic [SW-1:0] c_stage_last = SW'(NUM_STAGES - 1);
  localparam logic [DW-1:0] c_delay_last = DW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] c_deb_last   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          c_btn_active = 1'(BTN_ACTIVE);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // Button synchroniser and debouncer
  // --------------------------------------------------------------------------
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          deb_pressed_q, deb_pressed_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic          sync_pressed;

  assign sync_pressed = (sync2_q == c_btn_active);

  // Next-state for the synchroniser chain and debounce counter
  always_comb begin
    sync1_d       = i_btn;
    sync2_d       = sync1_q;
    deb_pressed_d = deb_pressed_q;
    deb_cnt_d     = '0;
    if (sync_pressed != deb_pressed_q) begin
      if (deb_cnt_q == c_deb_last) begin
        // Level held long enough: accept it and restart the count.
        deb_pressed_d = sync_pressed;
        deb_cnt_d     = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Button-path registers; reset parks the chain at the released level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q       <= ~c_btn_active;
      sync2_q       <= ~c_btn_active;
      deb_pressed_q <= 1'b0;
      deb_cnt_q     <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      deb_pressed_q <= deb_pressed_d;
      deb_cnt_q     <= deb_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Release sequencer
  // --------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [SW-1:0]           stage_q, stage_d;
  logic [DW-1:0]           delay_q, delay_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    ready_q, ready_d;

  // Next-state and registered-output values for the sequencer
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    delay_d = delay_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    case (state_q)
      ST_HOLD: begin
        rst_d   = '1;
        ready_d = 1'b0;
        stage_d = '0;
        delay_d = '0;
        if (!deb_pressed_q) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (deb_pressed_q) begin
          state_d = ST_HOLD;
          rst_d   = '1;
          ready_d = 1'b0;
          stage_d = '0;
          delay_d = '0;
        end else if (delay_q == c_delay_last) begin
          delay_d = '0;
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_q == SW'(i)) begin
              rst_d[i] = 1'b0;
            end
          end
          if (stage_q == c_stage_last) begin
            // Last stage just dropped: every bit is now low.
            state_d = ST_RUN;
            ready_d = 1'b1;
            stage_d = '0;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (deb_pressed_q) begin
          state_d = ST_HOLD;
          rst_d   = '1;
          ready_d = 1'b0;
          stage_d = '0;
          delay_d = '0;
        end
      end
      default: begin
        state_d = ST_HOLD;
        rst_d   = '1;
        ready_d = 1'b0;
        stage_d = '0;
        delay_d = '0;
      end
    endcase
  end

  // Sequencer registers; i_rst overrides everything, including a press
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_HOLD;
      stage_q <= '0;
      delay_q <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      delay_q <= delay_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign o_rst   = rst_q;
  assign o_ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_rst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rst_sequencer
//  Description : Scoreboard bench for rst_sequencer. dut_a: 3 stages, gap 4,
//                debounce 8, active-high button. dut_b: 1 stage, gap 1,
//                debounce 4, active-low button.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_btn, b_rst, b_btn;
  logic [2:0] a_out;
  logic       a_ready;
  logic [0:0] b_out;
  logic       b_ready;

  rst_sequencer #(
    .NUM_STAGES(3), .STAGE_DELAY(4), .DEBOUNCE_CYCLES(8), .BTN_ACTIVE(1)
  ) dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_btn(a_btn), .o_rst(a_out), .o_ready(a_ready)
  );

  rst_sequencer #(
    .NUM_STAGES(1), .STAGE_DELAY(1), .DEBOUNCE_CYCLES(4), .BTN_ACTIVE(0)
  ) dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_btn(b_btn), .o_rst(b_out), .o_ready(b_ready)
  );

  // Expected values are {o_ready, o_rst}
  localparam logic [3:0] A_HOLD = 4'b0111;
  localparam logic [3:0] A_RUN  = 4'b1000;
  localparam logic [1:0] B_HOLD = 2'b01;
  localparam logic [1:0] B_RUN  = 2'b10;

  typedef struct packed {
    logic [7:0] scen;
    logic [3:0] ea;
    logic [1:0] eb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;

  // dut_a outputs k edges after cycle 0 (gap 4: drops at 4, 8, 12)
  function automatic logic [3:0] exp_a(input int k);
    if (k < 4)       return 4'b0111;
    else if (k < 8)  return 4'b0110;
    else if (k < 12) return 4'b0100;
    else             return 4'b1000;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after its edge
  task automatic step(input logic ar, input logic ab, input logic br, input logic bb,
                      input logic [3:0] ea, input logic [1:0] eb, input logic [7:0] scen);
    exp_t e;
    @(negedge clk);
    #1;
    a_rst = ar;
    a_btn = ab;
    b_rst = br;
    b_btn = bb;
    e.scen = scen;
    e.ea   = ea;
    e.eb   = eb;
    sb.push_back(e);
  endtask

  task automatic a_step(input logic ar, input logic ab, input logic [3:0] ea,
                        input logic [7:0] scen);
    step(ar, ab, 1'b1, 1'b1, ea, B_HOLD, scen);
  endtask

  task automatic b_step(input logic br, input logic bb, input logic [1:0] eb,
                        input logic [7:0] scen);
    step(1'b1, 1'b0, br, bb, A_HOLD, eb, scen);
  endtask

  // Monitor: outputs are stable at the falling edge; one queue entry per cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      n_vec++;
      if ({a_ready, a_out} !== mon_e.ea) begin
        n_bad++;
        $display("FAIL scen%0d dut_a {ready,rst}: got %b want %b at %0t",
                 mon_e.scen, {a_ready, a_out}, mon_e.ea, $time);
      end
      n_vec++;
      if ({b_ready, b_out} !== mon_e.eb) begin
        n_bad++;
        $display("FAIL scen%0d dut_b {ready,rst}: got %b want %b at %0t",
                 mon_e.scen, {b_ready, b_out}, mon_e.eb, $time);
      end
    end
  end

  initial begin
    a_rst = 1'b1; a_btn = 1'b0;
    b_rst = 1'b1; b_btn = 1'b1;

    // 1: reset for 5 cycles, then the staged release
    repeat (5) a_step(1'b1, 1'b0, A_HOLD, 8'd1);
    for (int k = 0; k < 16; k++) a_step(1'b0, 1'b0, exp_a(k), 8'd1);

    // 2: press in RUN for 13 cycles; HOLD from the 11th edge
    for (int j = 1; j <= 13; j++) a_step(1'b0, 1'b1, (j <= 10) ? A_RUN : A_HOLD, 8'd2);
    // release: debounced after 10 edges, cycle 0 on the 11th
    for (int j = 1; j <= 26; j++) a_step(1'b0, 1'b0, (j <= 10) ? A_HOLD : exp_a(j - 11), 8'd2);

    // 3: 7-cycle glitch in RUN, then one straddling the 8-edge release
    for (int j = 0; j < 7; j++)  a_step(1'b0, 1'b1, A_RUN, 8'd3);
    for (int j = 0; j < 12; j++) a_step(1'b0, 1'b0, A_RUN, 8'd3);
    a_step(1'b1, 1'b0, A_HOLD, 8'd3);
    for (int k = 0; k < 16; k++) a_step(1'b0, (k >= 5 && k <= 11), exp_a(k), 8'd3);

    // 4: one-cycle reset pulse mid-sequence restarts from cycle 0
    a_step(1'b1, 1'b0, A_HOLD, 8'd4);
    for (int k = 0; k < 6; k++)  a_step(1'b0, 1'b0, exp_a(k), 8'd4);
    a_step(1'b1, 1'b0, A_HOLD, 8'd4);
    for (int k = 0; k < 16; k++) a_step(1'b0, 1'b0, exp_a(k), 8'd4);

    // 5: single stage, gap 1 (button released level is 1)
    repeat (3) b_step(1'b1, 1'b1, B_HOLD, 8'd5);
    b_step(1'b0, 1'b1, B_HOLD, 8'd5);
    repeat (4) b_step(1'b0, 1'b1, B_RUN, 8'd5);
    // reset and press together: HOLD
    b_step(1'b1, 1'b0, B_HOLD, 8'd6);
    // synchroniser restarts released, so the sequence runs until the press debounces
    for (int j = 1; j <= 10; j++) b_step(1'b0, 1'b0, (j >= 2 && j <= 6) ? B_RUN : B_HOLD, 8'd6);
    // release: debounced at edge 6, cycle 0 at 7, released at 8
    for (int j = 1; j <= 10; j++) b_step(1'b0, 1'b1, (j >= 8) ? B_RUN : B_HOLD, 8'd6);

    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
